hls_launch_ctrl: RTL
====================

Name: hls_launch_ctrl

Overview:
Parametrised launch/capture controller for HLS-generated kernels on the board top level. It replaces the single-kernel WAIT/START/EXE/DONE sequencer with NUM_CH independent kernel channels. It synchronises and edge-detects the push-button "go", pulses start to the enabled kernels, and captures each kernel's return value on its finish pulse. It adds a cycle timeout, relaunch from DONE/TIMEOUT, and a run counter for LED/UART reporting.

Parameters:
NUM_CH, 2, number of kernel channels (1..8)
RET_W, 32, return value width per channel
TMO_W, 24, width of timeout limit and EXE cycle timer

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
go  in  1  raw push-button level, asynchronous to clk, active-high
ch_enable  in  NUM_CH  channels to launch; sampled on accepted go edge
timeout_limit  in  TMO_W  max EXE cycles; 0 = timeout disabled
finish  in  NUM_CH  per-kernel one-cycle finish pulse
return_val  in  NUM_CH*RET_W  per-kernel return value; channel i at [i*RET_W +: RET_W]
start  out  NUM_CH  one-cycle start pulse per enabled channel
ret_q  out  NUM_CH*RET_W  captured return values
done_mask  out  NUM_CH  channels that have finished this run
busy  out  1  high in START or EXE
done  out  1  high in DONE
timed_out  out  1  high in TIMEOUT
state  out  3  current state encoding, drives LEDG
run_count  out  8  launches since reset, saturating

Behaviour:
- Reset (async, active-high): state=IDLE, start=0, ret_q=0, done_mask=0, run_count=0, timer=0, en_q=0, sync/edge flops=0.
- State encoding: IDLE=3'b001, START=3'b010, EXE=3'b011, DONE=3'b100, TIMEOUT=3'b101. Unused codes return to IDLE.
- go path: 2-flop synchroniser, then edge register. go_rise = sync & ~prev. The first go_rise occurs 3 clk edges after go rises.
- Launch: accepted only in IDLE, DONE or TIMEOUT, when go_rise=1 and ch_enable!=0.
  - On that clock edge: en_q<=ch_enable, done_mask<=0, ret_q<=0, timer<=0, run_count+=1 (saturates at 255), state<=START.
  - go_rise with ch_enable==0: ignored; state and all outputs unchanged.
  - go_rise in START or EXE: ignored.
- START: lasts exactly 1 cycle, then state goes to EXE. start=en_q (registered output, 0 in every other state). finish is ignored in START.
- EXE, per cycle:
  - hit = finish & en_q & ~done_mask.
  - For each hit bit i: ret_q slice i <= return_val slice i, done_mask[i] <= 1.
  - Finish on a non-enabled or already-done channel is ignored and causes no recapture.
  - complete = ((done_mask|hit) == en_q). If complete, state goes to DONE on the next cycle.
  - Otherwise, if timeout_limit!=0 and timer==timeout_limit-1, state goes to TIMEOUT.
  - Otherwise timer increments.
  - Completion and timeout in the same cycle: completion wins (DONE).
- DONE / TIMEOUT: ret_q and done_mask are held. In TIMEOUT, done_mask shows the channels that did finish. Both states wait for the next launch. finish is ignored in both.
- Timer does not wrap. Its maximum reachable value is timeout_limit-1. With limit 0 it holds at 2^TMO_W-1 once saturated.
- Mid-run reset: immediate return to IDLE with all outputs cleared. A start pulse in flight is truncated.
- busy=(state==START||state==EXE), done=(state==DONE), timed_out=(state==TIMEOUT). All three are decoded combinationally from the state register.

Decomposition:
- Shared package/include: state encodings, LAUNCH_STATE_W=3, RUN_COUNT_W=8.
- Sub-module go_sync_edge: 2-flop synchroniser plus rising-edge detector with async reset. It is reused for other KEY inputs.
- Per-channel capture uses a generate loop inside hls_launch_ctrl, not a separate module.

Test Plan:
- Reset then go pulse, ch_enable=2'b11, timeout_limit=0. Finish ch0 (value 32'h0000_0005) 4 cycles after start, ch1 (32'hDEAD_BEEF) 9 cycles after start -> start=2'b11 for 1 cycle; done_mask 01 then 11; DONE; ret_q={DEAD_BEEF,00000005}; run_count=1.
- ch_enable=2'b01, finish pulses on both channels -> ch1 finish ignored; done_mask=01; ret_q ch1 slice=0; DONE one cycle after ch0 finish.
- timeout_limit=10, never finish -> exactly 10 EXE cycles, then state=3'b101 and timed_out=1; done_mask=0. A new go edge relaunches: run_count=2, ret_q cleared.
- timeout_limit=5, final finish on the 5th EXE cycle -> DONE, not TIMEOUT.
- go held high for 100 cycles; second go edge during EXE; go with ch_enable=0 in IDLE -> single launch only; the two ignored events cause no state or counter change.
- Assert reset mid-EXE with done_mask=01 -> same cycle: state=3'b001, ret_q=0, done_mask=0, run_count=0, start=0. 256 launches -> run_count holds at 255.

Source files
------------

// File: rtl/hls_launch_ctrl_pkg.sv
// Shared definitions for the HLS kernel launch/capture controller:
// state encodings (also shown on the board LEDs), widths and small helpers.
package hls_launch_ctrl_pkg;

  localparam int LAUNCH_STATE_W = 3;
  localparam int RUN_COUNT_W    = 8;

  typedef enum logic [LAUNCH_STATE_W-1:0] {
    ST_IDLE    = 3'b001,
    ST_START   = 3'b010,
    ST_EXE     = 3'b011,
    ST_DONE    = 3'b100,
    ST_TIMEOUT = 3'b101
  } launch_state_e;

  // Increment that sticks at all-ones so the reported run count never wraps.
  function automatic logic [RUN_COUNT_W-1:0] sat_inc(input logic [RUN_COUNT_W-1:0] v);
    logic [RUN_COUNT_W-1:0] r;
    if (v == {RUN_COUNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(RUN_COUNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/hls_launch_ctrl_if.sv
// Kernel-side handshake bundle: start pulses out to the kernels, finish
// pulses and return values back from them.
interface hls_launch_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int RET_W  = 32
);
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       finish;
  logic [NUM_CH*RET_W-1:0] return_val;

  modport master (
    output start,
    input  finish,
    input  return_val
  );

  modport slave (
    input  start,
    output finish,
    output return_val
  );
endinterface

// File: rtl/hls_launch_ctrl_go_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous
// push-button level. The rise output is combinational from the edge register,
// so a consumer acts on it at the third clock edge after the input rises.
module go_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchroniser chain and previous-value register for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/hls_launch_ctrl.sv
// Launch/capture controller for NUM_CH independent HLS kernels. A synchronised
// push-button edge launches the enabled channels, each kernel's return value
// is captured on its finish pulse, and the run ends in DONE when every enabled
// channel has finished or in TIMEOUT when the EXE cycle budget runs out.
module hls_launch_ctrl
  import hls_launch_ctrl_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int RET_W  = 32,
  parameter int TMO_W  = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      go,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic [TMO_W-1:0]          timeout_limit,
  hls_launch_ctrl_if.master         kif,
  output logic [NUM_CH*RET_W-1:0]   ret_q,
  output logic [NUM_CH-1:0]         done_mask,
  output logic                      busy,
  output logic                      done,
  output logic                      timed_out,
  output logic [LAUNCH_STATE_W-1:0] state,
  output logic [RUN_COUNT_W-1:0]    run_count
);

  launch_state_e          state_q, state_d;
  logic [NUM_CH-1:0]      en_q, en_d;
  logic [NUM_CH-1:0]      done_mask_q, done_mask_d;
  logic [NUM_CH-1:0]      start_q, start_d;
  logic [TMO_W-1:0]       timer_q, timer_d;
  logic [RUN_COUNT_W-1:0] run_count_q, run_count_d;

  logic              go_rise_s;
  logic              launch_s;
  logic              exe_s;
  logic [NUM_CH-1:0] hit_s;
  logic              complete_s;
  logic              tmo_s;

  go_sync_edge u_go_sync (
    .clk     (clk),
    .rst     (reset),
    .async_i (go),
    .rise_o  (go_rise_s)
  );

  // Only the first finish of an enabled channel counts; repeats and strays
  // from disabled channels are dropped here.
  assign exe_s      = (state_q == ST_EXE);
  assign hit_s      = kif.finish & en_q & ~done_mask_q;
  assign complete_s = ((done_mask_q | hit_s) == en_q);
  assign tmo_s      = (timeout_limit != {TMO_W{1'b0}}) &&
                      (timer_q == (timeout_limit - {{(TMO_W-1){1'b0}}, 1'b1}));

  // Next-state, launch bookkeeping, completion tracking and EXE timer.
  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    done_mask_d = done_mask_q;
    start_d     = {NUM_CH{1'b0}};
    timer_d     = timer_q;
    run_count_d = run_count_q;
    launch_s    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (go_rise_s && (ch_enable != {NUM_CH{1'b0}})) begin
          launch_s    = 1'b1;
          state_d     = ST_START;
          en_d        = ch_enable;
          done_mask_d = {NUM_CH{1'b0}};
          start_d     = ch_enable;
          timer_d     = {TMO_W{1'b0}};
          run_count_d = sat_inc(run_count_q);
        end else begin
          state_d = state_q;
        end
      end
      ST_START: begin
        state_d = ST_EXE;
      end
      ST_EXE: begin
        done_mask_d = done_mask_q | hit_s;
        if (complete_s) begin
          state_d = ST_DONE;
        end else if (tmo_s) begin
          state_d = ST_TIMEOUT;
        end else if (timer_q != {TMO_W{1'b1}}) begin
          timer_d = timer_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end else begin
          timer_d = timer_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      en_q        <= {NUM_CH{1'b0}};
      done_mask_q <= {NUM_CH{1'b0}};
      start_q     <= {NUM_CH{1'b0}};
      timer_q     <= {TMO_W{1'b0}};
      run_count_q <= {RUN_COUNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      done_mask_q <= done_mask_d;
      start_q     <= start_d;
      timer_q     <= timer_d;
      run_count_q <= run_count_d;
    end
  end

  // Per-channel return-value capture: cleared on launch, loaded on first hit.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [RET_W-1:0] cap_q, cap_d;

    // Select the next captured value for this channel.
    always_comb begin
      if (launch_s) begin
        cap_d = {RET_W{1'b0}};
      end else if (exe_s && hit_s[i]) begin
        cap_d = kif.return_val[i*RET_W +: RET_W];
      end else begin
        cap_d = cap_q;
      end
    end

    // Capture register for this channel.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cap_q <= {RET_W{1'b0}};
      end else begin
        cap_q <= cap_d;
      end
    end

    assign ret_q[i*RET_W +: RET_W] = cap_q;
  end

  assign kif.start = start_q;
  assign done_mask = done_mask_q;
  assign run_count = run_count_q;
  assign state     = state_q;
  assign busy      = (state_q == ST_START) || (state_q == ST_EXE);
  assign done      = (state_q == ST_DONE);
  assign timed_out = (state_q == ST_TIMEOUT);

endmodule
